// File: rtl/ball_motion_if.sv
// Signal bundle between the ball physics engine and its neighbours (paddle, block stage, draw_ball).
// All inputs are single-cycle strobes or levels sampled on the CLK edge; there is no back-pressure.
interface ball_motion_if;
  logic        frame_tick;
  logic        start;
  logic [11:0] paddle_x;
  logic [9:0]  paddle_size;
  logic        block_hit_h;
  logic        block_hit_v;
  logic [11:0] ball_x;
  logic [10:0] ball_y;
  logic        moving;
  logic        lost;
  logic [5:0]  lives;
  logic        game_over;
  logic [1:0]  dbgState;

  modport slave (
    input  frame_tick, start, paddle_x, paddle_size, block_hit_h, block_hit_v,
    output ball_x, ball_y, moving, lost, lives, game_over, dbgState
  );

  modport master (
    output frame_tick, start, paddle_x, paddle_size, block_hit_h, block_hit_v,
    input  ball_x, ball_y, moving, lost, lives, game_over, dbgState
  );
endinterface

// File: rtl/ball_motion.sv
// Ball physics: once per frame moves the ball, bounces it off walls, paddle and blocks,
// and tracks lives / game-over.
module ball_motion #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_Y  = 460,
  parameter int SPEED     = 2,
  parameter int LIVES     = 3,
  parameter int START_X   = 316
) (
  input  logic         CLK,
  input  logic         reset,
  ball_motion_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, LOST = 2'd2, OVER = 2'd3} state_t;

  // 14 bits so paddle_x + paddle_size never wraps
  localparam logic signed [13:0] ZERO  = 14'sd0;
  localparam logic signed [13:0] SPD   = 14'(SPEED);
  localparam logic signed [13:0] BSZ   = 14'(BALL_SIZE);
  localparam logic signed [13:0] HALFB = 14'(BALL_SIZE / 2);
  localparam logic signed [13:0] XMAX  = 14'(SCREEN_W - BALL_SIZE);
  localparam logic signed [13:0] YDROP = 14'(SCREEN_H - BALL_SIZE);
  localparam logic signed [13:0] PADY  = 14'(PADDLE_Y);

  state_t      state, stateNext;
  logic [11:0] ballX, ballXNext;
  logic [10:0] ballY, ballYNext;
  logic        dxLeft, dxLeftNext, dyDown, dyDownNext;
  logic        pendH, pendHNext, pendV, pendVNext;
  logic [5:0]  lives, livesNext;

  logic signed [13:0] sx, sy, px, ps, halfPs, nx, ny, track;
  logic               flipLeft, flipDown, topHit, paddleHit, dropOut;

  assign sx       = $signed({2'b00, ballX});
  assign sy       = $signed({3'b000, ballY});
  assign px       = $signed({2'b00, bus.paddle_x});
  assign ps       = $signed({4'b0000, bus.paddle_size});
  assign halfPs   = $signed({5'b00000, bus.paddle_size[9:1]});
  assign track    = px + halfPs - HALFB;

  assign flipLeft = dxLeft ^ (pendH | bus.block_hit_h);
  assign flipDown = dyDown ^ (pendV | bus.block_hit_v);
  assign nx       = flipLeft ? sx - SPD : sx + SPD;
  assign ny       = flipDown ? sy + SPD : sy - SPD;

  assign topHit    = !flipDown && (ny <= ZERO);
  assign paddleHit = flipDown && (sy + BSZ <= PADY) && (ny + BSZ >= PADY) &&
                     (nx + BSZ > px) && (nx < px + ps);
  assign dropOut   = !topHit && !paddleHit && (ny >= YDROP);

  always_comb begin
    stateNext  = state;
    ballXNext  = ballX;
    ballYNext  = ballY;
    dxLeftNext = dxLeft;
    dyDownNext = dyDown;
    pendHNext  = pendH;
    pendVNext  = pendV;
    livesNext  = lives;
    case (state)
      IDLE: begin
        if (track < ZERO)      ballXNext = 12'd0;
        else if (track > XMAX) ballXNext = XMAX[11:0];
        else                   ballXNext = track[11:0];
        ballYNext = 11'(PADDLE_Y - BALL_SIZE);
        pendHNext = 1'b0;
        pendVNext = 1'b0;
        if (bus.start) begin
          stateNext  = MOVE;
          dxLeftNext = 1'b0;
          dyDownNext = 1'b0;
        end
      end
      MOVE: begin
        pendHNext = pendH | bus.block_hit_h;
        pendVNext = pendV | bus.block_hit_v;
        if (bus.frame_tick) begin
          pendHNext = 1'b0;
          pendVNext = 1'b0;
          if (dropOut) begin
            // ball keeps its last on-screen position while LOST is reported
            stateNext = LOST;
          end else begin
            dxLeftNext = flipLeft;
            dyDownNext = flipDown;
            if (nx <= ZERO) begin
              ballXNext  = 12'd0;
              dxLeftNext = 1'b0;
            end else if (nx >= XMAX) begin
              ballXNext  = XMAX[11:0];
              dxLeftNext = 1'b1;
            end else begin
              ballXNext = nx[11:0];
            end
            if (topHit) begin
              ballYNext  = 11'd0;
              dyDownNext = 1'b1;
            end else if (paddleHit) begin
              ballYNext  = 11'(PADDLE_Y - BALL_SIZE);
              dyDownNext = 1'b0;
              dxLeftNext = (nx + HALFB < px + halfPs);
            end else begin
              ballYNext = ny[10:0];
            end
          end
        end
      end
      LOST: begin
        livesNext = (lives != 6'd0) ? lives - 6'd1 : 6'd0;
        if (livesNext == 6'd0) begin
          stateNext = OVER;
        end else begin
          stateNext  = IDLE;
          dxLeftNext = 1'b0;
          dyDownNext = 1'b0;
        end
      end
      OVER: begin
        stateNext = OVER;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= IDLE;
      ballX  <= 12'(START_X);
      ballY  <= 11'(PADDLE_Y - BALL_SIZE);
      dxLeft <= 1'b0;
      dyDown <= 1'b0;
      pendH  <= 1'b0;
      pendV  <= 1'b0;
      lives  <= 6'(LIVES);
    end else begin
      state  <= stateNext;
      ballX  <= ballXNext;
      ballY  <= ballYNext;
      dxLeft <= dxLeftNext;
      dyDown <= dyDownNext;
      pendH  <= pendHNext;
      pendV  <= pendVNext;
      lives  <= livesNext;
    end
  end

  assign bus.ball_x    = ballX;
  assign bus.ball_y    = ballY;
  assign bus.moving    = (state == MOVE);
  assign bus.lost      = (state == LOST);
  assign bus.game_over = (state == OVER);
  assign bus.lives     = lives;
  assign bus.dbgState  = state;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed scenarios against fixed coordinates plus a randomized run
// checked cycle-by-cycle against a frame-level behavioural model.
module tb_ball_motion;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ball_motion_if bus();
  ball_motion dut (.CLK(CLK), .reset(reset), .bus(bus));

  always #20 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  int    ex, ey, eLives;
  bit    eRight, eUp, ePendH, ePendV;
  string ePhase = "idle";
  logic [W-1:0] exp_q[$];

  task automatic model_step(input bit rst, tk, st, hh, hv, input int px, ps);
    int nx, ny, x, y, tr;
    bit r, u;
    if (rst) begin
      ex = 316; ey = 452; eRight = 1; eUp = 1; ePendH = 0; ePendV = 0;
      eLives = 3; ePhase = "idle";
    end else if (ePhase == "idle") begin
      tr = px + ps / 2 - 4;
      if (tr < 0) tr = 0;
      if (tr > 632) tr = 632;
      ex = tr; ey = 452; ePendH = 0; ePendV = 0;
      if (st) begin ePhase = "fly"; eRight = 1; eUp = 1; end
    end else if (ePhase == "fly") begin
      if (tk) begin
        r = eRight ^ (ePendH | hh);
        u = eUp ^ (ePendV | hv);
        ePendH = 0; ePendV = 0;
        nx = ex + (r ? 2 : -2);
        ny = ey + (u ? -2 : 2);
        if (nx <= 0) begin x = 0; r = 1; end
        else if (nx >= 632) begin x = 632; r = 0; end
        else x = nx;
        if (u && ny <= 0) begin
          y = 0; u = 0;
        end else if (!u && ey + 8 <= 460 && ny + 8 >= 460 && nx + 8 > px && nx < px + ps) begin
          y = 452; u = 1; r = !(nx + 4 < px + ps / 2);
        end else if (ny >= 472) begin
          ePhase = "lost";
        end else begin
          y = ny;
        end
        if (ePhase == "fly") begin ex = x; ey = y; eRight = r; eUp = u; end
      end else begin
        ePendH = ePendH | hh;
        ePendV = ePendV | hv;
      end
    end else if (ePhase == "lost") begin
      eLives = (eLives > 0) ? eLives - 1 : 0;
      if (eLives == 0) ePhase = "over";
      else begin ePhase = "idle"; eRight = 1; eUp = 1; end
    end
  endtask

  function automatic logic [W-1:0] exp_pack();
    return {12'(ex), 11'(ey), ePhase == "fly", ePhase == "lost", 6'(eLives), ePhase == "over"};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_cycle(input bit rst, tk, st, hh, hv);
    @(negedge CLK);
    reset = rst;
    bus.frame_tick = tk; bus.start = st; bus.block_hit_h = hh; bus.block_hit_v = hv;
    model_step(rst, tk, st, hh, hv, int'(bus.paddle_x), int'(bus.paddle_size));
    exp_q.push_back(exp_pack());
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      drive_cycle(0, 1, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.paddle_x = 12'd280; bus.paddle_size = 10'd64;
    do_reset();
    checks++;
    if (bus.ball_x !== 12'd316 || bus.ball_y !== 11'd452 || bus.lives !== 6'd3 ||
        bus.moving !== 1'b0 || bus.lost !== 1'b0 || bus.game_over !== 1'b0 || bus.dbgState !== 2'd0) begin
      errors++;
      $display("FAIL reset_values ball=(%0d,%0d) lives=%0d mv=%b lost=%b go=%b st=%0d expected (316,452) 3 0 0 0 0",
               bus.ball_x, bus.ball_y, bus.lives, bus.moving, bus.lost, bus.game_over, bus.dbgState);
    end
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.ball_x !== 12'd308 || bus.ball_y !== 11'd452 || bus.lives !== 6'd3 || bus.moving !== 1'b0) begin
      errors++;
      $display("FAIL idle_track ball=(%0d,%0d) lives=%0d mv=%b expected (308,452) 3 0",
               bus.ball_x, bus.ball_y, bus.lives, bus.moving);
    end
    bus.paddle_x = 12'd300;
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.ball_x !== 12'd328) begin
      errors++; $display("FAIL idle_retrack ball_x=%0d expected 328", bus.ball_x);
    end
  endtask

  task automatic test_launch_run();
    bus.paddle_x = 12'd280; bus.paddle_size = 10'd64;
    do_reset();
    drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0);
    tick_n(1);
    checks++;
    if (bus.ball_x !== 12'd310 || bus.ball_y !== 11'd450 || bus.moving !== 1'b1) begin
      errors++; $display("FAIL first_tick ball=(%0d,%0d) mv=%b expected (310,450) 1", bus.ball_x, bus.ball_y, bus.moving);
    end
    tick_n(161);
    checks++;
    if (bus.ball_x !== 12'd632 || bus.ball_y !== 11'd128) begin
      errors++; $display("FAIL right_wall ball=(%0d,%0d) expected (632,128)", bus.ball_x, bus.ball_y);
    end
    tick_n(1);
    checks++;
    if (bus.ball_x !== 12'd630 || bus.ball_y !== 11'd126) begin
      errors++; $display("FAIL after_right_wall ball=(%0d,%0d) expected (630,126)", bus.ball_x, bus.ball_y);
    end
    tick_n(63);
    checks++;
    if (bus.ball_x !== 12'd504 || bus.ball_y !== 11'd0) begin
      errors++; $display("FAIL top_wall ball=(%0d,%0d) expected (504,0)", bus.ball_x, bus.ball_y);
    end
    tick_n(1);
    checks++;
    if (bus.ball_x !== 12'd502 || bus.ball_y !== 11'd2) begin
      errors++; $display("FAIL after_top_wall ball=(%0d,%0d) expected (502,2)", bus.ball_x, bus.ball_y);
    end
    tick_n(234);
    drive_cycle(0, 1, 0, 0, 0);
    checks++;
    if (bus.lost !== 1'b1 || bus.moving !== 1'b0 || bus.ball_x !== 12'd34 || bus.ball_y !== 11'd470) begin
      errors++; $display("FAIL drop_out lost=%b mv=%b ball=(%0d,%0d) expected 1 0 (34,470)",
                         bus.lost, bus.moving, bus.ball_x, bus.ball_y);
    end
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.lost !== 1'b0 || bus.lives !== 6'd2 || bus.dbgState !== 2'd0) begin
      errors++; $display("FAIL after_lost lost=%b lives=%0d st=%0d expected 0 2 0", bus.lost, bus.lives, bus.dbgState);
    end
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (bus.ball_x !== 12'd308 || bus.ball_y !== 11'd452) begin
      errors++; $display("FAIL retrack_after_lost ball=(%0d,%0d) expected (308,452)", bus.ball_x, bus.ball_y);
    end
  endtask

  task automatic test_paddle_bounce();
    bus.paddle_x = 12'd280; bus.paddle_size = 10'd64;
    do_reset();
    drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, 0, 0);
    tick_n(451);
    checks++;
    if (bus.ball_x !== 12'd54 || bus.ball_y !== 11'd450) begin
      errors++; $display("FAIL pre_bounce ball=(%0d,%0d) expected (54,450)", bus.ball_x, bus.ball_y);
    end
    bus.paddle_x = 12'd20;
    drive_cycle(0, 1, 0, 0, 0);
    checks++;
    if (bus.ball_x !== 12'd52 || bus.ball_y !== 11'd452 || bus.lost !== 1'b0 || bus.moving !== 1'b1) begin
      errors++; $display("FAIL paddle_bounce ball=(%0d,%0d) lost=%b mv=%b expected (52,452) 0 1",
                         bus.ball_x, bus.ball_y, bus.lost, bus.moving);
    end
    drive_cycle(0, 0, 0, 0, 0);
    tick_n(1);
    checks++;
    if (bus.ball_x !== 12'd54 || bus.ball_y !== 11'd450 || bus.lives !== 6'd3) begin
      errors++; $display("FAIL after_bounce ball=(%0d,%0d) lives=%0d expected (54,450) 3", bus.ball_x, bus.ball_y, bus.lives);
    end
  endtask

  task automatic test_block_hits();
    bus.paddle_x = 12'd280; bus.paddle_size = 10'd64;
    do_reset();
    drive_cycle(0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 1, 0, 0);
    drive_cycle(0, 1, 0, 1, 0);
    checks++;
    if (bus.ball_x !== 12'd306 || bus.ball_y !== 11'd450) begin
      errors++; $display("FAIL hit_h_same_tick ball=(%0d,%0d) expected (306,450)", bus.ball_x, bus.ball_y);
    end
    drive_cycle(0, 0, 0, 0, 0);
    tick_n(1);
    checks++;
    if (bus.ball_x !== 12'd304 || bus.ball_y !== 11'd448) begin
      errors++; $display("FAIL hits_consumed ball=(%0d,%0d) expected (304,448)", bus.ball_x, bus.ball_y);
    end
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0);
    tick_n(1);
    checks++;
    if (bus.ball_x !== 12'd302 || bus.ball_y !== 11'd450) begin
      errors++; $display("FAIL pending_v ball=(%0d,%0d) expected (302,450)", bus.ball_x, bus.ball_y);
    end
    tick_n(1);
    tick_n(1);
    checks++;
    if (bus.ball_x !== 12'd298 || bus.ball_y !== 11'd450) begin
      errors++; $display("FAIL pending_cleared ball=(%0d,%0d) expected (298,450)", bus.ball_x, bus.ball_y);
    end
  endtask

  task automatic test_game_over();
    bus.paddle_x = 12'd280; bus.paddle_size = 10'd64;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 0, 0);
      drive_cycle(0, 0, 1, 0, 0);
      tick_n(462);
      checks++;
      if (bus.lives !== 6'(2 - i)) begin
        errors++; $display("FAIL miss_%0d lives=%0d expected %0d", i, bus.lives, 2 - i);
      end
    end
    checks++;
    if (bus.game_over !== 1'b1 || bus.moving !== 1'b0 || bus.ball_x !== 12'd34 || bus.ball_y !== 11'd470) begin
      errors++; $display("FAIL game_over go=%b mv=%b ball=(%0d,%0d) expected 1 0 (34,470)",
                         bus.game_over, bus.moving, bus.ball_x, bus.ball_y);
    end
    drive_cycle(0, 0, 1, 0, 0);
    tick_n(4);
    checks++;
    if (bus.game_over !== 1'b1 || bus.lives !== 6'd0 || bus.ball_x !== 12'd34 || bus.ball_y !== 11'd470) begin
      errors++; $display("FAIL over_frozen go=%b lives=%0d ball=(%0d,%0d) expected 1 0 (34,470)",
                         bus.game_over, bus.lives, bus.ball_x, bus.ball_y);
    end
    drive_cycle(1, 0, 0, 0, 0);
    checks++;
    if (bus.game_over !== 1'b0 || bus.lives !== 6'd3 || bus.moving !== 1'b0 || bus.ball_x !== 12'd316) begin
      errors++; $display("FAIL reset_from_over go=%b lives=%0d mv=%b x=%0d expected 0 3 0 316",
                         bus.game_over, bus.lives, bus.moving, bus.ball_x);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] got, exp;
    bit tk, st, hh, hv, rst;
    bus.paddle_x = 12'd280; bus.paddle_size = 10'd64;
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.paddle_size = 10'($urandom_range(16, 128));
      if ($urandom_range(0, 1) == 0)
        bus.paddle_x = 12'((ex > 560) ? 560 : ((ex < 40) ? 0 : ex - $urandom_range(0, 40)));
      else if ($urandom_range(0, 31) == 0)
        bus.paddle_x = 12'($urandom_range(0, 560));
      rst = ($urandom_range(0, 499) == 0);
      tk  = ($urandom_range(0, 2) == 0);
      st  = ($urandom_range(0, 39) == 0);
      hh  = ($urandom_range(0, 19) == 0);
      hv  = ($urandom_range(0, 19) == 0);
      drive_cycle(rst, tk, st, hh, hv);
      got = {bus.ball_x, bus.ball_y, bus.moving, bus.lost, bus.lives, bus.game_over};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle_%0d got x=%0d y=%0d mv=%b lost=%b lives=%0d go=%b expected x=%0d y=%0d mv=%b lost=%b lives=%0d go=%b",
                 c, got[31:20], got[19:9], got[8], got[7], got[6:1], got[0],
                 exp[31:20], exp[19:9], exp[8], exp[7], exp[6:1], exp[0]);
      end
    end
  endtask

  initial begin
    bus.frame_tick = 0; bus.start = 0; bus.block_hit_h = 0; bus.block_hit_v = 0;
    bus.paddle_x = 12'd280; bus.paddle_size = 10'd64;
    test_reset();
    test_launch_run();
    test_paddle_bounce();
    test_block_hits();
    test_game_over();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout simulation exceeded 5ms, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
